// File: rtl/bit_insertion_8x16_seq_if.sv
// Slice-in / word-out bus for bit_insertion_8x16_seq.
// The o_err signal is present only when BIT_INSERTION_OVERLAP_CHECK_EN is defined.
interface bit_insertion_8x16_seq_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int IN_DATA_WIDTH = DATA_WIDTH >> 1,
  parameter int COMMAND_WIDTH = $clog2(DATA_WIDTH)
);
  logic                     i_valid;
  logic [IN_DATA_WIDTH-1:0] i_data_bus;
  logic                     i_en;
  logic [COMMAND_WIDTH-1:0] i_cmd;
  logic                     i_flush;
  logic                     o_ready;
  logic                     o_valid;
  logic [DATA_WIDTH-1:0]    o_data_bus;
  logic [DATA_WIDTH-1:0]    o_mask;
  logic                     i_ready;
`ifdef BIT_INSERTION_OVERLAP_CHECK_EN
  logic                     o_err;
`endif

  // The driver of slices and consumer of words.
  modport master (
    output i_valid, i_data_bus, i_en, i_cmd, i_flush, i_ready,
`ifdef BIT_INSERTION_OVERLAP_CHECK_EN
    input  o_err,
`endif
    input  o_ready, o_valid, o_data_bus, o_mask
  );

  // The insertion block itself.
  modport slave (
    input  i_valid, i_data_bus, i_en, i_cmd, i_flush, i_ready,
`ifdef BIT_INSERTION_OVERLAP_CHECK_EN
    output o_err,
`endif
    output o_ready, o_valid, o_data_bus, o_mask
  );
endinterface

// File: rtl/bit_insertion_8x16_seq.sv
// bit_insertion_8x16_seq: places 8-bit slices into a 16-bit accumulator at a
// commanded offset (0..8), tracks written bits, and hands complete or flushed
// words to a one-entry valid/ready output register.
// Optional macro BIT_INSERTION_OVERLAP_CHECK_EN: rejects inserts that touch
// already-written bits and pulses o_err for one cycle.
//
// state        | meaning
// ST_EMPTY     | mask is zero, nothing accumulated
// ST_PARTIAL   | some bits written, word not yet complete
// ST_FULL_WAIT | word complete/flushed, waiting for output register; o_ready=0
module bit_insertion_8x16_seq #(
  parameter int DATA_WIDTH    = 16,
  parameter int IN_DATA_WIDTH = DATA_WIDTH >> 1,
  parameter int COMMAND_WIDTH = $clog2(DATA_WIDTH)
) (
  input logic                      clk,
  input logic                      rst,
  bit_insertion_8x16_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_PARTIAL   = 2'd1,
    ST_FULL_WAIT = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] SLICE_ONES = {{(DATA_WIDTH-IN_DATA_WIDTH){1'b0}}, {IN_DATA_WIDTH{1'b1}}};

  state_t                   state;
  logic [DATA_WIDTH-1:0]    acc;
  logic [DATA_WIDTH-1:0]    mask;

  logic [COMMAND_WIDTH-1:0] offset;
  logic [DATA_WIDTH-1:0]    slice_mask;
  logic [DATA_WIDTH-1:0]    slice_data;
  logic                     accept;
  logic                     overlap;
  logic                     do_ins;
  logic [DATA_WIDTH-1:0]    acc_n;
  logic [DATA_WIDTH-1:0]    mask_n;
  logic                     want_xfer;
  logic                     drain;
  logic                     out_free;

  // Next accumulator contents and transfer decision for this cycle.
  always_comb begin
    offset     = bus.i_cmd[3] ? ({1'b0, bus.i_cmd[2:0]} + 4'd1) : 4'd0;
    slice_mask = SLICE_ONES << offset;
    slice_data = {{(DATA_WIDTH-IN_DATA_WIDTH){1'b0}}, bus.i_data_bus} << offset;
    accept     = bus.i_valid & bus.i_en & bus.o_ready;
`ifdef BIT_INSERTION_OVERLAP_CHECK_EN
    overlap    = accept & (|(slice_mask & mask));
`else
    overlap    = 1'b0;
`endif
    do_ins     = accept & ~overlap;
    acc_n      = do_ins ? ((acc & ~slice_mask) | slice_data) : acc;
    mask_n     = do_ins ? (mask | slice_mask) : mask;
    want_xfer  = (do_ins & (mask_n == {DATA_WIDTH{1'b1}})) |
                 (bus.i_flush & bus.i_en & bus.o_ready & (mask_n != '0));
    drain      = bus.o_valid & bus.i_ready;
    out_free   = ~bus.o_valid | bus.i_ready;
  end

  // Accumulator FSM plus registered output word, handshake and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_EMPTY;
      acc            <= '0;
      mask           <= '0;
      bus.o_ready    <= 1'b1;
      bus.o_valid    <= 1'b0;
      bus.o_data_bus <= '0;
      bus.o_mask     <= '0;
`ifdef BIT_INSERTION_OVERLAP_CHECK_EN
      bus.o_err      <= 1'b0;
`endif
    end else begin
`ifdef BIT_INSERTION_OVERLAP_CHECK_EN
      bus.o_err <= overlap;
`endif
      if (drain) bus.o_valid <= 1'b0;
      case (state)
        ST_FULL_WAIT: begin
          if (out_free) begin
            bus.o_valid    <= 1'b1;
            bus.o_data_bus <= acc;
            bus.o_mask     <= mask;
            acc            <= '0;
            mask           <= '0;
            state          <= ST_EMPTY;
            bus.o_ready    <= 1'b1;
          end
        end
        default: begin
          if (want_xfer && out_free) begin
            bus.o_valid    <= 1'b1;
            bus.o_data_bus <= acc_n;
            bus.o_mask     <= mask_n;
            acc            <= '0;
            mask           <= '0;
            state          <= ST_EMPTY;
          end else if (want_xfer) begin
            acc         <= acc_n;
            mask        <= mask_n;
            state       <= ST_FULL_WAIT;
            bus.o_ready <= 1'b0;
          end else begin
            acc   <= acc_n;
            mask  <= mask_n;
            state <= (mask_n == '0) ? ST_EMPTY : ST_PARTIAL;
          end
        end
      endcase
    end
  end

endmodule
